// File: rtl/pio_link_pkg.sv
// Protocol constants for the FPGA<->ARM PIO link, shared by the buffer-fill
// receiver and the drain transmitter.
package pio_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    SEND_HI,
    SEND_LO,
    SEND_EOB
  } pioState_t;

  localparam logic [15:0] PIO_TAG_HI = 16'h0045;
  localparam logic [15:0] PIO_TAG_LO = 16'h0048;

  localparam logic [31:0] ACK_HI  = 32'h0000_0003;
  localparam logic [31:0] ACK_LO  = 32'h0000_0006;
  localparam logic [31:0] ACK_EOB = 32'h0000_0007;
  localparam logic [31:0] MSG_EOB = 32'h0000_0007;

  localparam logic [6:0] HALF_LAST = 7'h7f;

endpackage

// File: rtl/drain_buffer.sv
// FPGA-to-ARM transmitter: drains one half of the ping-pong buffer RAM as
// tagged 16-bit PIO blocks, closes the half with an end-of-block message.
module drain_buffer
  import pio_link_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] TAG_HI       = PIO_TAG_HI,
  parameter logic [15:0] TAG_LO       = PIO_TAG_LO
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] inputPio,
  output logic [31:0] outputPio,
  output logic [7:0]  addressAtBuffer,
  input  logic [31:0] dataFromBuffer,
  output logic        rden,
  input  logic        halfReady,
  output logic        workingAtFirstPosition,
  output logic        workingAtFinalPosition,
  output logic        halfDrained
);

  localparam logic [2:0] LAST_COUNT = 3'(READ_LATENCY - 1);

  pioState_t   state, stateNext;
  logic [31:0] word, wordNext;
  logic [31:0] outputPioNext;
  logic [7:0]  addressNext;
  logic [2:0]  count, countNext;
  logic        rdenNext, firstNext, finalNext, drainedNext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      outputPio              <= '0;
      addressAtBuffer        <= '0;
      rden                   <= 1'b0;
      workingAtFirstPosition <= 1'b0;
      workingAtFinalPosition <= 1'b0;
      halfDrained            <= 1'b0;
      word                   <= '0;
      count                  <= '0;
    end else begin
      state                  <= stateNext;
      outputPio              <= outputPioNext;
      addressAtBuffer        <= addressNext;
      rden                   <= rdenNext;
      workingAtFirstPosition <= firstNext;
      workingAtFinalPosition <= finalNext;
      halfDrained            <= drainedNext;
      word                   <= wordNext;
      count                  <= countNext;
    end
  end

  always_comb begin
    stateNext     = state;
    outputPioNext = outputPio;
    addressNext   = addressAtBuffer;
    rdenNext      = rden;
    firstNext     = workingAtFirstPosition;
    finalNext     = workingAtFinalPosition;
    drainedNext   = 1'b0;
    wordNext      = word;
    countNext     = count;

    unique case (state)
      IDLE: begin
        outputPioNext = '0;
        if (halfReady) begin
          firstNext = ~addressAtBuffer[7];
          finalNext = addressAtBuffer[7];
          rdenNext  = 1'b1;
          countNext = '0;
          stateNext = READ_WAIT;
        end
      end

      READ_WAIT: begin
        // The upper block is loaded straight from the RAM bus so it is on
        // outputPio the first clock of SEND_HI.
        if (count == LAST_COUNT) begin
          wordNext      = dataFromBuffer;
          outputPioNext = {TAG_HI, dataFromBuffer[31:16]};
          rdenNext      = 1'b0;
          countNext     = '0;
          stateNext     = SEND_HI;
        end else begin
          countNext = count + 3'd1;
        end
      end

      SEND_HI: begin
        if (inputPio == ACK_HI) begin
          outputPioNext = {TAG_LO, word[15:0]};
          stateNext     = SEND_LO;
        end
      end

      SEND_LO: begin
        if (inputPio == ACK_LO) begin
          if (addressAtBuffer[6:0] == HALF_LAST) begin
            outputPioNext = MSG_EOB;
            stateNext     = SEND_EOB;
          end else begin
            addressNext = addressAtBuffer + 8'd1;
            rdenNext    = 1'b1;
            countNext   = '0;
            stateNext   = READ_WAIT;
          end
        end
      end

      SEND_EOB: begin
        // Address wraps 0xff->0x00, which also flips the half select bit.
        if (inputPio == ACK_EOB) begin
          addressNext   = addressAtBuffer + 8'd1;
          outputPioNext = '0;
          drainedNext   = 1'b1;
          firstNext     = 1'b0;
          finalNext     = 1'b0;
          stateNext     = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_drain_buffer.sv
// Bench for drain_buffer: three lanes at read latencies 2, 1 and 4, each with
// its own RAM model and ARM responder checking the message stream.
module tb_drain_buffer;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] inputPio        [3];
  logic [31:0] outputPio       [3];
  logic [7:0]  addressAtBuffer [3];
  logic [31:0] dataFromBuffer  [3];
  logic        rden            [3];
  logic        halfReady       [3];
  logic        wFirst          [3];
  logic        wFinal          [3];
  logic        halfDrained     [3];
  bit          done            [3];
  logic [31:0] ram             [256];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clock = ~clock;

  task automatic checkEq(input int lane, input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL lane%0d %s got=%h expected=%h", lane, tag, got, exp);
    end
  endtask

  // Stall-cycle bus value: a stale ack code, unrelated junk, or an idle bus.
  function automatic logic [31:0] noise(input logic [31:0] staleCode);
    case ($urandom_range(0, 2))
      0:       return staleCode;
      1:       return $urandom | 32'h100;
      default: return '0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    int         age       = 0;
    logic       prevRden  = 1'b0;
    logic [7:0] lastAddr  = '0;

    drain_buffer #(.READ_LATENCY(L)) dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .inputPio              (inputPio[g]),
      .outputPio             (outputPio[g]),
      .addressAtBuffer       (addressAtBuffer[g]),
      .dataFromBuffer        (dataFromBuffer[g]),
      .rden                  (rden[g]),
      .halfReady             (halfReady[g]),
      .workingAtFirstPosition(wFirst[g]),
      .workingAtFinalPosition(wFinal[g]),
      .halfDrained           (halfDrained[g])
    );

    // RAM: read data is only correct once rden and the address have been
    // held for L cycles; before that the bus carries corrupted data.
    always @(posedge clock) begin
      #1;
      if (rden[g] && prevRden && addressAtBuffer[g] == lastAddr) age = age + 1;
      else age = rden[g] ? 1 : 0;
      prevRden = rden[g];
      lastAddr = addressAtBuffer[g];
      dataFromBuffer[g] = (age >= L) ? ram[addressAtBuffer[g]]
                                     : ram[addressAtBuffer[g]] ^ ($urandom | 32'h1);
    end

    // ARM responder: expects, per word, {0045,hi16} then {0048,lo16}, and a
    // 0x7 after the last word of each half. Drains half 0, half 1, then parks
    // in the middle of the first word of the next half 0.
    initial begin : agent
      logic [31:0] w;
      logic [7:0]  a, aNext;
      int unsigned n;
      inputPio[g]  = '0;
      halfReady[g] = 1'b0;
      @(posedge reset_n);
      @(negedge clock);
      halfReady[g] = 1'b1;
      for (int unsigned round = 0; round < 3; round++) begin
        for (int unsigned k = 0; k < 128; k++) begin
          a     = 8'((round % 2) * 128 + k);
          aNext = a + 8'd1;
          w     = ram[a];
          n = 0;
          while (outputPio[g][31:16] != 16'h0045 && n < 64) begin
            @(negedge clock);
            n++;
          end
          checkEq(L, "hi", outputPio[g], {16'h0045, w[31:16]});
          checkEq(L, "addr", 32'(addressAtBuffer[g]), 32'(a));
          checkEq(L, "flags", 32'({wFirst[g], wFinal[g]}), (round % 2 == 1) ? 32'd1 : 32'd2);
          checkEq(L, "rdenDrained", 32'({rden[g], halfDrained[g]}), 32'd0);
          if (k == 5)   halfReady[g] = 1'b0;
          if (k == 126) halfReady[g] = 1'b1;
          repeat ($urandom_range(0, 3)) begin
            inputPio[g] = noise(32'h6);
            @(negedge clock);
            checkEq(L, "hiHold", outputPio[g], {16'h0045, w[31:16]});
          end
          inputPio[g] = 32'h3;
          @(negedge clock);
          checkEq(L, "lo", outputPio[g], {16'h0048, w[15:0]});
          if (round == 2) break;
          repeat ($urandom_range(0, 3)) begin
            inputPio[g] = noise(32'h3);
            @(negedge clock);
            checkEq(L, "loHold", outputPio[g], {16'h0048, w[15:0]});
          end
          inputPio[g] = 32'h6;
          @(negedge clock);
          if (k < 127) begin
            checkEq(L, "nextAddr", 32'(addressAtBuffer[g]), 32'(aNext));
            checkEq(L, "nextRden", 32'(rden[g]), 32'd1);
          end else begin
            checkEq(L, "eob", outputPio[g], 32'h7);
            checkEq(L, "eobAddr", 32'(addressAtBuffer[g]), 32'(a));
          end
          inputPio[g] = noise(32'h6);
        end
        if (round < 2) begin
          repeat ($urandom_range(0, 3)) begin
            inputPio[g] = noise(32'h6);
            @(negedge clock);
            checkEq(L, "eobHold", outputPio[g], 32'h7);
          end
          halfReady[g] = (round == 1);
          inputPio[g]  = 32'h7;
          @(negedge clock);
          checkEq(L, "drained", 32'({halfDrained[g], wFirst[g], wFinal[g]}), 32'b100);
          checkEq(L, "halfAddr", 32'(addressAtBuffer[g]), 32'(aNext));
          checkEq(L, "idleOut", outputPio[g], 32'h0);
          inputPio[g] = noise(32'h7);
          @(negedge clock);
          if (round == 0) begin
            repeat (3) begin
              checkEq(L, "idleWait", 32'({halfDrained[g], rden[g], wFirst[g], wFinal[g]}), 32'd0);
              checkEq(L, "idleWaitOut", outputPio[g], 32'h0);
              @(negedge clock);
            end
            halfReady[g] = 1'b1;
          end else begin
            checkEq(L, "restart", 32'({halfDrained[g], rden[g], wFirst[g], wFinal[g]}), 32'b0110);
          end
        end
      end
      inputPio[g]  = '0;
      halfReady[g] = 1'b0;
      done[g]      = 1'b1;
    end
  end

  initial begin
    int unsigned n;
    foreach (ram[i]) ram[i] = $urandom;
    ram[0] = 32'hDEADBEEF;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      checkEq(i, "rstOut", outputPio[i], 32'h0);
      checkEq(i, "rstAddr", 32'(addressAtBuffer[i]), 32'h0);
      checkEq(i, "rstCtl", 32'({rden[i], wFirst[i], wFinal[i], halfDrained[i]}), 32'h0);
    end
    reset_n = 1'b1;

    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checkEq(-1, "allDone", 32'({done[0], done[1], done[2]}), 32'h7);
    for (int i = 0; i < 3; i++) checkEq(i, "parkLo", 32'(outputPio[i][31:16]), 32'h0048);

    // Asynchronous reset taken mid-cycle while every lane sits in SEND_LO.
    #3 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkEq(i, "asyncOut", outputPio[i], 32'h0);
      checkEq(i, "asyncAddr", 32'(addressAtBuffer[i]), 32'h0);
      checkEq(i, "asyncCtl", 32'({rden[i], wFirst[i], wFinal[i], halfDrained[i]}), 32'h0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        checkEq(i, "postOut", outputPio[i], 32'h0);
        checkEq(i, "postCtl", 32'({addressAtBuffer[i], rden[i], wFirst[i], wFinal[i]}), 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
